// File: rtl/iic_pkg.sv
// Shared types and constants for the iic_core register-access sequencer.
package iic_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BYTE = 3'd2,
    S_STOP_REQ  = 3'd3,
    S_RESP      = 3'd4
  } seq_state_e;

  localparam logic IIC_RD = 1'b1;
  localparam logic IIC_WR = 1'b0;

  localparam logic [1:0] IDX_FIRST   = 2'd0;
  localparam logic [1:0] IDX_REG     = 2'd1;
  localparam logic [1:0] IDX_LAST_WR = 2'd2;
  localparam logic [1:0] IDX_LAST_RD = 2'd1;

  function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rd);
    return {dev, rd};
  endfunction

endpackage

// File: rtl/iic_seq_timer.sv
// Wait-state watchdog for the sequencer, used only when IIC_SEQ_TIMEOUT_EN is defined.
module iic_seq_timer
  import iic_pkg::*;
#(
  parameter int unsigned LIMIT = 65535,
  parameter int unsigned W     = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the LIMIT-th enabled cycle since the last clear.
  assign expired = en && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/iic_reg_seq.sv
// Register read/write sequencer driving iic_core's byte handshake.
// Optional wait-state timeout abort: define IIC_SEQ_TIMEOUT_EN.
module iic_reg_seq
  import iic_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned TO_W           = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  // Request handshake: a request transfers on a rising clock edge where
  // req_valid && req_ready; the requester holds req_* stable until then.
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       core_start,
  output logic       core_stop,
  output logic       core_rw,
  output logic [7:0] core_din,
  input  logic [7:0] core_dout,
  input  logic       core_busy,
  input  logic       core_sending
);

  seq_state_e  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        phase_q, phase_d;
  logic        rw_q, rw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        abort_q, abort_d;
  logic        free_q, free_d;

  logic        accept;
  logic        last_byte;
  logic        rd_byte;
  logic [7:0]  byte_din;
  logic        to_expired;

  assign accept    = req_valid && req_ready;
  assign req_ready = (state_q == S_IDLE) && reset_n;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign free_d    = !core_sending && !core_busy;

  // Phase 1 exists only for reads: address byte with R bit, then the data byte.
  assign rd_byte   = (rw_q == IIC_RD) && phase_q && (idx_q == IDX_LAST_RD);
  assign last_byte = (rw_q == IIC_RD) ? (idx_q == IDX_LAST_RD) : (idx_q == IDX_LAST_WR);

  always_comb begin
    byte_din = '0;
    if (idx_q == IDX_FIRST) begin
      byte_din = addr_byte(dev_q, phase_q);
    end else if (rd_byte) begin
      byte_din = '0;
    end else if (idx_q == IDX_REG) begin
      byte_din = reg_q;
    end else begin
      byte_din = wdata_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    phase_d    = phase_q;
    rw_d       = rw_q;
    dev_d      = dev_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    abort_d    = abort_q;
    core_start = 1'b0;
    core_stop  = 1'b0;
    core_rw    = 1'b0;
    core_din   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          rw_d    = req_rw;
          dev_d   = req_dev;
          reg_d   = req_reg;
          wdata_d = req_wdata;
          idx_d   = IDX_FIRST;
          phase_d = 1'b0;
          rdata_d = '0;
          err_d   = 1'b0;
          abort_d = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        core_din = byte_din;
        core_rw  = rd_byte;
        // A frame's first byte waits until the bus was seen fully idle.
        core_start = (idx_q != IDX_FIRST) || free_q;
        if (to_expired) begin
          abort_d = 1'b1;
          state_d = S_STOP_REQ;
        end else if (core_start && core_busy && core_sending) begin
          state_d = S_WAIT_BYTE;
        end
      end
      S_WAIT_BYTE: begin
        core_din = byte_din;
        core_rw  = rd_byte;
        if (to_expired) begin
          abort_d = 1'b1;
          state_d = S_STOP_REQ;
        end else if (!core_busy) begin
          if (rd_byte) begin
            rdata_d = core_dout;
          end
          if (last_byte) begin
            state_d = S_STOP_REQ;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_STOP_REQ: begin
        core_stop = 1'b1;
        if (!core_sending) begin
          if (abort_q) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_RESP;
          end else if ((rw_q == IIC_RD) && !phase_q) begin
            phase_d = 1'b1;
            idx_d   = IDX_FIRST;
            state_d = S_ISSUE;
          end else begin
            state_d = S_RESP;
          end
        end else if (to_expired) begin
          if (abort_q) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_RESP;
          end else begin
            abort_d = 1'b1;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef IIC_SEQ_TIMEOUT_EN
  logic to_en;
  logic to_clr;

  assign to_en  = (state_q == S_ISSUE) || (state_q == S_WAIT_BYTE) || (state_q == S_STOP_REQ);
  assign to_clr = (state_d != state_q) || (abort_d != abort_q);

  iic_seq_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (TO_W)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (to_clr),
    .en      (to_en),
    .expired (to_expired)
  );
`else
  assign to_expired = 1'b0;
`endif

  to_w_fits_limit: assert property (@(posedge clock) disable iff (!reset_n)
    (2 ** TO_W) > TIMEOUT_CYCLES);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= IDX_FIRST;
      phase_q <= 1'b0;
      rw_q    <= IIC_WR;
      dev_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      free_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      rw_q    <= rw_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      free_q  <= free_d;
    end
  end

endmodule

// File: tb/tb_iic_reg_seq.sv
// Self-checking bench for iic_reg_seq with a behavioural iic_core model.
module tb_iic_reg_seq;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       req_valid, req_ready, req_rw;
  logic [6:0] req_dev;
  logic [7:0] req_reg, req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       core_start, core_stop, core_rw;
  logic [7:0] core_din, core_dout;
  logic       core_busy, core_sending;

  always #5 clock = ~clock;

  iic_reg_seq dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rw       (req_rw),
    .req_dev      (req_dev),
    .req_reg      (req_reg),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .core_start   (core_start),
    .core_stop    (core_stop),
    .core_rw      (core_rw),
    .core_din     (core_din),
    .core_dout    (core_dout),
    .core_busy    (core_busy),
    .core_sending (core_sending)
  );

  int n_vec = 0;
  int n_err = 0;
  int prot_bad = 0;
  int rd_started = 0;
  int unsigned cyc = 0;

  // Bus event: {is_stop, rw, din}; din is not compared for read bytes.
  logic [9:0] bus_exp_q[$];
  logic [8:0] rsp_exp_q[$];
  logic [7:0] rd_data_q[$];

  bit stall = 1'b0;
  bit long_rd = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_bus(input logic [9:0] ev);
    if (bus_exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL bus_unexpected: got event 0x%0h expected none", ev);
    end else begin
      check("bus_event", ev, bus_exp_q.pop_front());
    end
  endtask

  // Reference model: the frame list a register access must produce.
  task automatic push_expect(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                             input logic [7:0] wd, input logic [7:0] rdv);
    if (!rw) begin
      bus_exp_q.push_back({2'b00, dev, 1'b0});
      bus_exp_q.push_back({2'b00, rg});
      bus_exp_q.push_back({2'b00, wd});
      bus_exp_q.push_back(10'h200);
      rsp_exp_q.push_back({1'b0, 8'h00});
    end else begin
      bus_exp_q.push_back({2'b00, dev, 1'b0});
      bus_exp_q.push_back({2'b00, rg});
      bus_exp_q.push_back(10'h200);
      bus_exp_q.push_back({2'b00, dev, 1'b1});
      bus_exp_q.push_back(10'h100);
      bus_exp_q.push_back(10'h200);
      rd_data_q.push_back(rdv);
      rsp_exp_q.push_back({1'b0, rdv});
    end
  endtask

  // Behavioural iic_core: registered reaction to start/stop.
  logic       n_busy, n_send;
  logic [7:0] n_dout;
  int         m_cnt, m_scnt;
  bit         m_stopping;

  initial begin
    core_busy = 1'b0;
    core_sending = 1'b0;
    core_dout = 8'h00;
    m_cnt = 0;
    m_scnt = 0;
    m_stopping = 1'b0;
    forever begin
      @(negedge clock);
      n_busy = core_busy;
      n_send = core_sending;
      n_dout = core_dout;
      if (!reset_n) begin
        n_busy = 1'b0;
        n_send = 1'b0;
        n_dout = 8'h00;
        m_cnt = 0;
        m_stopping = 1'b0;
      end else begin
        if (core_start && core_stop) prot_bad++;
        if (core_busy) begin
          if (!stall) begin
            m_cnt--;
            if (m_cnt <= 0) n_busy = 1'b0;
          end
        end else if (m_stopping) begin
          if (core_start) prot_bad++;
          m_scnt--;
          if (m_scnt <= 0) begin
            n_send = 1'b0;
            m_stopping = 1'b0;
          end
        end else if (core_start) begin
          compare_bus(core_rw ? 10'h100 : {2'b00, core_din});
          n_busy = 1'b1;
          n_send = 1'b1;
          m_cnt = (core_rw && long_rd) ? 12 : int'($urandom_range(1, 4));
          if (core_rw) begin
            rd_started++;
            if (rd_data_q.size() != 0) n_dout = rd_data_q.pop_front();
            else prot_bad++;
          end
        end else if (core_stop && core_sending) begin
          compare_bus(10'h200);
          m_stopping = 1'b1;
          m_scnt = int'($urandom_range(1, 3));
        end
      end
      @(posedge clock);
      #1;
      core_busy = n_busy;
      core_sending = n_send;
      core_dout = n_dout;
    end
  end

  // Response monitor and back-to-back accept timing.
  int unsigned rsp_cyc = 0;
  bit b2b_pending = 1'b0;

  initial begin
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (req_valid && req_ready) begin
          if (b2b_pending) check("b2b_accept_gap", cyc - rsp_cyc, 1);
          b2b_pending = 1'b0;
        end
        if (rsp_valid) begin
          if (rsp_exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_unexpected: got rsp_valid with 0x%0h expected none", {rsp_err, rsp_rdata});
          end else begin
            check("rsp", {rsp_err, rsp_rdata}, rsp_exp_q.pop_front());
          end
          rsp_cyc = cyc;
          b2b_pending = req_valid;
        end
      end else begin
        b2b_pending = 1'b0;
      end
    end
  end

  task automatic issue(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                       input logic [7:0] wd, input logic [7:0] rdv, input bit hold);
    bit ok = 1'b0;
    req_rw = rw;
    req_dev = dev;
    req_reg = rg;
    req_wdata = wd;
    req_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      return;
    end
    push_expect(rw, dev, rg, wd, rdv);
    @(posedge clock);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clock);
      if (bus_exp_q.size() == 0 && rsp_exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, {31'd0, ok}, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    bus_exp_q.delete();
    rsp_exp_q.delete();
    rd_data_q.delete();
    repeat (cycles) @(posedge clock);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_rd;
    int bad;
    bit ok;
    reset_n = 1'b0;
    req_valid = 1'b0;
    req_rw = 1'b0;
    req_dev = '0;
    req_reg = '0;
    req_wdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata, core_start, core_stop,
                            core_rw, core_din}, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("ready_after_reset", req_ready, 1);
    @(posedge clock);
    #1;

    issue(1'b0, 7'h3D, 8'h10, 8'hA5, 8'h00, 1'b0);
    wait_idle("write_done");
    check("write_rsp_hold", {rsp_err, rsp_rdata}, 0);

    issue(1'b1, 7'h3D, 8'h20, 8'h00, 8'h5C, 1'b0);
    wait_idle("read_done");
    check("read_rdata_hold", rsp_rdata, 8'h5C);
    check("idle_ready", req_ready, 1);

    issue(1'b0, 7'h11, 8'h01, 8'h02, 8'h00, 1'b1);
    issue(1'b1, 7'h12, 8'h03, 8'h00, 8'hC3, 1'b1);
    issue(1'b0, 7'h13, 8'h04, 8'h05, 8'h00, 1'b0);
    wait_idle("b2b_done");

    for (int i = 0; i < 16; i++) begin
      logic rw;
      rw = 1'($urandom_range(0, 1));
      issue(rw, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
    end
    req_valid = 1'b0;
    wait_idle("random_done");

    long_rd = 1'b1;
    start_rd = rd_started;
    issue(1'b1, 7'h3D, 8'h20, 8'h00, 8'h99, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (rd_started != start_rd) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_read_byte", {31'd0, ok}, 1);
    repeat (3) @(posedge clock);
    #1;
    do_reset(1);
    @(negedge clock);
    check("midreset_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata, core_start, core_stop,
                               core_rw, core_din}, 0);
    long_rd = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("midreset_ready", req_ready, 1);
    @(posedge clock);
    #1;
    issue(1'b0, 7'h2A, 8'h33, 8'h44, 8'h00, 1'b0);
    wait_idle("after_reset_write");

    stall = 1'b1;
    issue(1'b0, 7'h50, 8'h60, 8'h70, 8'h00, 1'b0);
    repeat (5) @(posedge clock);
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clock);
      if (rsp_valid || core_start || req_ready) bad++;
    end
    check("stall_quiet", bad, 0);
    check("stall_first_byte_only", bus_exp_q.size(), 3);
    @(posedge clock);
    #1;
    do_reset(2);
    stall = 1'b0;
    reset_n = 1'b1;
    issue(1'b1, 7'h3D, 8'h7E, 8'h00, 8'h3C, 1'b0);
    wait_idle("after_stall_read");
    check("after_stall_rdata", rsp_rdata, 8'h3C);

    check("protocol_violations", prot_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iic_reg_seq.md
Name: iic_reg_seq

Overview:
- Register-access sequencer in front of iic_core.
- Accepts one register read or write request per transaction from a requester, then drives iic_core's byte-level start/stop/rw/din handshake through the full I2C frame.
- Returns read data with a completion response.
- Replaces hand-written demo FSMs as the single owner of the iic_core control inputs.

Parameters:
- TIMEOUT_CYCLES, 65535, max cycles in any core wait state before abort (used only with IIC_SEQ_TIMEOUT_EN)
- TO_W, 16, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle; request accepted on req_valid&&req_ready
- req_rw  in  1  1=register read, 0=register write
- req_dev  in  7  7-bit device address
- req_reg  in  8  register address
- req_wdata  in  8  write data (ignored for reads)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read data, valid with rsp_valid on reads; 0 on writes
- rsp_err  out  1  timeout abort flag, valid with rsp_valid
- core_start  out  1  to iic_core start
- core_stop  out  1  to iic_core stop
- core_rw  out  1  to iic_core rw (1=shift byte in)
- core_din  out  8  to iic_core din
- core_dout  in  8  from iic_core dout
- core_busy  in  1  from iic_core busy (byte in progress)
- core_sending  in  1  from iic_core sending (bus owned START..STOP)

Behaviour:
- Reset (reset_n low at posedge): state IDLE; req_ready=0 during reset; all other outputs=0. First cycle after reset, req_ready=1.
- Reset mid-transaction abandons the frame with no rsp_valid. iic_core shares reset_n, so the bus is released by the core.
- Request latching: on accept, latch rw/dev/reg/wdata; req_ready drops the next cycle. Byte list:
  - Write: {dev,0}w, reg w, wdata w, STOP.
  - Read: {dev,0}w, reg w, STOP, {dev,1}w, data r, STOP.
  - No repeated start. Byte index counter 0..2 plus phase bit for the read's second frame.
- Core handshake per byte:
  - ISSUE: core_start=1 with core_din/core_rw held stable until core_busy&&core_sending is sampled.
  - WAIT_BYTE: core_start=0; wait for core_busy==0; byte done. For an rd byte, capture core_dout that same cycle.
- STOP handling:
  - STOP_REQ: core_stop=1 held until core_sending==0, then core_stop=0.
  - Then either start the read second frame (if phase 0 of a read) or go to RESP.
- RESP: rsp_valid=1 for exactly one cycle with rsp_rdata/rsp_err; next cycle IDLE with req_ready=1. rsp_rdata/rsp_err hold until the next accept.
- States: IDLE -> ISSUE -> WAIT_BYTE -> (ISSUE | STOP_REQ) -> (ISSUE | RESP) -> IDLE.
- A new frame may not begin ISSUE until core_sending==0 and core_busy==0 are both sampled.
- Simultaneous events: req_valid while not ready is ignored, and the requester holds it. core_busy fall and core_sending fall in one cycle is legal in STOP_REQ only; in WAIT_BYTE, sending low is ignored.
- Latency, write: accept -> 3 byte handshakes -> STOP -> rsp_valid. Minimum 2 cycles of sequencer overhead per byte with an instant core.

Optional Feature:
- Macro IIC_SEQ_TIMEOUT_EN.
- Defined:
  - A TO_W-bit counter clears on every state change and increments in ISSUE, WAIT_BYTE and STOP_REQ.
  - Reaching TIMEOUT_CYCLES forces core_start=0, core_stop=1.
  - Then waits up to TIMEOUT_CYCLES more for sending low, then goes to RESP with rsp_err=1, rsp_rdata=0.
- Undefined: no counter; waits are unbounded; rsp_err tied 0.

Decomposition:
- Package iic_pkg: state encoding constants (S_IDLE, S_ISSUE, S_WAIT_BYTE, S_STOP_REQ, S_RESP), IIC_RD/IIC_WR bit constants, byte-index limits.
- One natural sub-module, iic_seq_timer: the timeout counter with clear/enable/expired, instantiated only under IIC_SEQ_TIMEOUT_EN.

Test Plan:
- Write dev=0x3D reg=0x10 data=0xA5, behavioural core model -> core_din sequence 0x7A, 0x10, 0xA5 all with rw=0, one STOP, rsp_valid once, rsp_err=0.
- Read dev=0x3D reg=0x20, model returns 0x5C -> din 0x7A, 0x20, STOP, 0x7B (rw=0), read byte (rw=1), STOP; rsp_rdata=0x5C.
- Back-to-back requests with req_valid held high -> second accepted exactly one cycle after first rsp_valid; no overlap of core_start with core_sending high from the prior frame.
- reset_n low while in WAIT_BYTE of the read second frame -> next cycle all outputs 0, no rsp_valid; a new write afterwards completes normally.
- Macro defined, TIMEOUT_CYCLES=100, model holds core_busy high forever -> core_stop asserted at cycle 100 of WAIT_BYTE; rsp_valid with rsp_err=1 after sending released.
- Macro undefined, same stall for 10000 cycles -> no rsp_valid, core_start stays 0, req_ready stays 0.
